// File: rtl/wallace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wallace_pkg
// Purpose  : Shared definitions for the Wallace multiplier datapath: the
//            final-adder FSM state encoding and the default operand geometry
//            used by the partial-product tree and the final adder.
// Revision : 1.0  initial release
// ============================================================================
package wallace_pkg;

  // Product width and number of partial-product rows fed to the tree.
  localparam int MUL_W   = 32;
  localparam int PP_ROWS = 16;

  // Final carry-propagate adder control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } fa_state_t;

endpackage : wallace_pkg
`default_nettype wire

// File: rtl/pp_final_adder_cpa_chunk.sv
`default_nettype none
// ============================================================================
// Module   : cpa_chunk
// Purpose  : Combinational CHUNK-bit adder with carry-in and carry-out. One
//            instance is time-shared across all chunks of the final adder.
// Ports    : a, b  in  CHUNK  addend chunks
//            cin   in  1      carry from the previous (lower) chunk
//            sum   out CHUNK  chunk sum
//            cout  out 1      carry into the next (higher) chunk
// Revision : 1.0  initial release
// ============================================================================
module cpa_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  // One extra bit on each operand captures the carry out of the chunk MSB.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule : cpa_chunk
`default_nettype wire

// File: rtl/pp_final_adder.sv
`default_nettype none
// ============================================================================
// Module   : pp_final_adder
// Purpose  : Final carry-propagate stage of the Wallace multiplier. Resolves
//            the redundant sum/carry pair from the adder tree into a binary
//            product, CHUNK bits per cycle with a registered inter-chunk
//            carry. Valid/ready handshake on both input and output sides.
// Ports    : clk, rst            clock, synchronous active-high reset
//            in_valid/in_ready   input handshake for the s/c pair
//            s, c                sum and weight-aligned carry vectors
//            out_valid/out_ready output handshake for p
//            p                   (s + c) mod 2^WIDTH
//            cout                final MSB carry (PP_FINAL_ADDER_COUT_EN only)
//            busy                high while adding or holding a result
// Config   : define PP_FINAL_ADDER_COUT_EN to add the cout output port.
// Revision : 1.0  initial release
// ============================================================================
module pp_final_adder
  import wallace_pkg::*;
#(
  parameter int WIDTH = MUL_W,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p,
`ifdef PP_FINAL_ADDER_COUT_EN
  output logic             cout,
`endif
  output logic             busy
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  fa_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q,     s_d;
  logic [WIDTH-1:0] c_q,     c_d;
  logic [WIDTH-1:0] p_q,     p_d;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             accept;

  // Acceptance is blocked during the reset cycle so nothing is latched
  // that the reset would immediately throw away.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign p         = p_q;

`ifdef PP_FINAL_ADDER_COUT_EN
  // After the last chunk the carry register holds the MSB carry; it is
  // cleared on acceptance, so it never shows a stale value with out_valid.
  assign cout = carry_q;
`endif

  // The single adder is steered to the chunk selected by idx.
  assign chunk_a = s_q[idx_q*CHUNK +: CHUNK];
  assign chunk_b = c_q[idx_q*CHUNK +: CHUNK];

  cpa_chunk #(
    .CHUNK (CHUNK)
  ) u_cpa_chunk (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    s_d     = s_q;
    c_d     = c_q;
    p_d     = p_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          s_d     = s;
          c_d     = c;
          idx_d   = '0;
          carry_d = 1'b0;
          // Clearing p makes unwritten upper chunks read as zero.
          p_d     = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        p_d[idx_q*CHUNK +: CHUNK] = chunk_sum;
        carry_d                   = chunk_cout;
        // idx is left at the last chunk rather than wrapped.
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        // Input side is deliberately ignored here; p and carry stay frozen.
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      c_q     <= c_d;
      p_q     <= p_d;
    end
  end

endmodule : pp_final_adder
`default_nettype wire

// File: tb/tb_pp_final_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pp_final_adder
// Purpose  : Directed self-checking bench for pp_final_adder. Instance A uses
//            the default 32/8 geometry; instance B uses CHUNK=32.
// Revision : 1.0  initial release
// ============================================================================
module tb_pp_final_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [31:0] a_s, a_c, a_p;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [31:0] b_s, b_c, b_p;
`ifdef PP_FINAL_ADDER_COUT_EN
  logic        a_cout, b_cout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pp_final_adder #(.WIDTH(32), .CHUNK(8)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .s         (a_s),
    .c         (a_c),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .p         (a_p),
`ifdef PP_FINAL_ADDER_COUT_EN
    .cout      (a_cout),
`endif
    .busy      (a_busy)
  );

  pp_final_adder #(.WIDTH(32), .CHUNK(32)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .s         (b_s),
    .c         (b_c),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .p         (b_p),
`ifdef PP_FINAL_ADDER_COUT_EN
    .cout      (b_cout),
`endif
    .busy      (b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after the acceptance edge; returns at the negedge of the
  // first cycle with out_valid high (or after the cycle budget runs out).
  task automatic wait_result_a(input string tag, input logic [31:0] exp_p,
                               input logic exp_cout);
    int  lat;
    bit  seen;
    lat  = 1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (a_out_valid) begin
        seen = 1'b1;
      end else begin
        if (k == 0) begin
          check({tag, "_busy_in_add"}, a_busy, 1);
          check({tag, "_in_ready_in_add"}, a_in_ready, 0);
        end
        @(posedge clk); #1;
        lat++;
      end
    end
    check({tag, "_seen"}, seen, 1);
    check({tag, "_latency"}, lat, 5);
    check({tag, "_p"}, a_p, exp_p);
`ifdef PP_FINAL_ADDER_COUT_EN
    check({tag, "_cout"}, a_cout, exp_cout);
`else
    if (exp_cout === 1'bx) $display("unreachable");
`endif
  endtask

  task automatic run_op_a(input string tag, input logic [31:0] s, input logic [31:0] c,
                          input logic [31:0] exp_p, input logic exp_cout);
    a_s = s; a_c = c; a_in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, a_in_ready, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    wait_result_a(tag, exp_p, exp_cout);
  endtask

  initial begin
    int    nres;
    int    cyc;
    int    r_cyc [2];
    logic [31:0] r_p [2];
    bit    drop;
    bit    seen;
    int    lat;

    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_s = '0; a_c = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_s = '0; b_c = '0;

    // Reset state, sampled while rst is still high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_a",  a_in_ready,  0);
    check("rst_out_valid_a", a_out_valid, 0);
    check("rst_p_a",         a_p,         0);
    check("rst_busy_a",      a_busy,      0);
    check("rst_in_ready_b",  b_in_ready,  0);
    check("rst_p_b",         b_p,         0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready_a", a_in_ready, 1);
    check("post_rst_in_ready_b", b_in_ready, 1);
    @(posedge clk); #1;

    // Basic add, no inter-chunk carries.
    run_op_a("add1", 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("add1_out_valid_after", a_out_valid, 0);
    check("add1_in_ready_after",  a_in_ready,  1);
    @(posedge clk); #1;

    // Carry ripples through every chunk and out of the MSB.
    run_op_a("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
    @(posedge clk); #1;

    // Backpressure: DONE held with a competing input offered.
    a_out_ready = 1'b0;
    run_op_a("bp", 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0);
    @(posedge clk); #1;
    a_s = 32'h0000_0100; a_c = 32'h0000_0200; a_in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_hold_p",         a_p,         32'h0000_000C);
      check("bp_hold_in_ready",  a_in_ready,  0);
      check("bp_hold_out_valid", a_out_valid, 1);
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    check("bp_both_in_ready", a_in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_u1_in_ready",  a_in_ready,  1);
    check("bp_u1_out_valid", a_out_valid, 0);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    wait_result_a("bp_next", 32'h0000_0300, 1'b0);
    @(posedge clk); #1;

    // Reset in the middle of ADD, at idx=2.
    a_s = 32'h0102_0304; a_c = 32'h1020_3040; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_partial_p", a_p,    32'h0000_3344);
    check("midrst_busy",      a_busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", a_out_valid, 0);
    check("midrst_p",         a_p,         0);
    check("midrst_in_ready",  a_in_ready,  1);
    check("midrst_busy_low",  a_busy,      0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_out_valid) seen = 1'b1;
    end
    check("midrst_no_result", seen, 0);
    @(posedge clk); #1;

    // Back-to-back with out_ready held high.
    a_s = 32'h89AB_CDEF; a_c = 32'h7654_3210; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_s = 32'h0000_FFFF; a_c = 32'h0000_0001;
    nres = 0; cyc = 1; drop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_out_valid && nres < 2) begin
        r_cyc[nres] = cyc;
        r_p[nres]   = a_p;
        nres++;
      end
      if (a_in_valid && a_in_ready) drop = 1'b1;
      @(posedge clk); #1;
      if (drop) begin
        a_in_valid = 1'b0;
        drop = 1'b0;
      end
      cyc++;
    end
    check("b2b_count", nres, 2);
    if (nres == 2) begin
      check("b2b_first_cycle", r_cyc[0], 5);
      check("b2b_gap",         r_cyc[1] - r_cyc[0], 6);
      check("b2b_p0",          r_p[0], 32'hFFFF_FFFF);
      check("b2b_p1",          r_p[1], 32'h0001_0000);
    end

    // CHUNK=32 instance: single-cycle ADD.
    b_s = 32'h8000_0000; b_c = 32'h8000_0000; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 1; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (b_out_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check("c32_seen",    seen, 1);
    check("c32_latency", lat,  2);
    check("c32_p",       b_p,  32'h0000_0000);
`ifdef PP_FINAL_ADDER_COUT_EN
    check("c32_cout",    b_cout, 1);
`endif
    @(posedge clk); #1;

    b_s = 32'h7FFF_FFFF; b_c = 32'h0000_0001; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 1; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (b_out_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check("c32b_latency", lat, 2);
    check("c32b_p",       b_p, 32'h8000_0000);
`ifdef PP_FINAL_ADDER_COUT_EN
    check("c32b_cout",    b_cout, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pp_final_adder
`default_nettype wire
